// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Grant encoding, misalignment masks and the alignment helper.
package mem_port_arbiter_pkg;

  localparam int STARVE_LIMIT_DEF = 4;

  localparam logic [1:0] WORD_MIS_MASK = 2'b11;
  localparam logic [1:0] HALF_MIS_MASK = 2'b01;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_DM
  } gnt_e;

  // Halfword wins over byte; byte accesses are always aligned.
  function automatic logic misaligned(
    input logic [1:0] lsb,
    input logic       half,
    input logic       is_byte
  );
    if (half)    return |(lsb & HALF_MIS_MASK);
    if (is_byte) return 1'b0;
    return |(lsb & WORD_MIS_MASK);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// Fetch starvation counter for the memory port arbiter.
// Saturates at LIMIT stalled cycles and then forces a fetch grant.
module mem_port_arbiter_starve #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic if_ack,
  output logic force_if
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Count stalled fetch cycles, clear on grant or idle.
  always_comb begin
    cnt_d = cnt_q;
    if (!if_req || if_ack) begin
      cnt_d = '0;
    end else if (cnt_q != LIM) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign force_if = (cnt_q == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Data-memory port arbiter between fetch and load/store ports.
// Data port wins unless fetch has starved; responses registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int   STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter logic ALIGN_CHECK  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic        dm_half,
  input  logic        dm_byte,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_fault,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_half,
  output logic        mem_byte,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  gnt_e gnt;
  logic force_if;
  logic if_win;
  logic dm_win;
  logic mis;

  logic        if_rvalid_q, if_rvalid_d;
  logic [31:0] if_rdata_q,  if_rdata_d;
  logic        dm_rvalid_q, dm_rvalid_d;
  logic [31:0] dm_rdata_q,  dm_rdata_d;
  logic        dm_fault_q,  dm_fault_d;

  mem_port_arbiter_starve #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_ack   (if_ack),
    .force_if (force_if)
  );

  assign mis = ALIGN_CHECK &&
               misaligned(dm_addr[1:0], dm_half, dm_byte);

  assign if_win = rst_n && if_req && (force_if || !dm_req);
  assign dm_win = rst_n && dm_req && !(force_if && if_req);

  // Pick one requester and drive the memory strobes.
  always_comb begin
    gnt       = GNT_NONE;
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_half  = 1'b0;
    mem_byte  = 1'b0;
    mem_wdata = '0;
    unique case (1'b1)
      if_win: begin
        gnt      = GNT_IF;
        mem_addr = if_addr;
        mem_read = 1'b1;
      end
      dm_win: begin
        gnt       = GNT_DM;
        mem_addr  = dm_addr;
        mem_read  = !dm_we && !mis;
        mem_write = dm_we && !mis;
        mem_half  = dm_half;
        mem_byte  = dm_byte && !dm_half;
        mem_wdata = dm_wdata;
      end
      default: gnt = GNT_NONE;
    endcase
  end

  assign if_ack = (gnt == GNT_IF);
  assign dm_ack = (gnt == GNT_DM);

  // Capture read data on grant and form one-cycle pulses.
  always_comb begin
    if_rvalid_d = if_ack;
    if_rdata_d  = if_ack ? mem_rdata : if_rdata_q;
    dm_rvalid_d = dm_ack && !dm_we && !mis;
    dm_rdata_d  = dm_rvalid_d ? mem_rdata : dm_rdata_q;
    dm_fault_d  = dm_ack && mis;
  end

  // Response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rvalid_q <= 1'b0;
      dm_rdata_q  <= '0;
      dm_fault_q  <= 1'b0;
    end else begin
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_fault_q  <= dm_fault_d;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_fault  = dm_fault_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte memory model.
// Table vectors plus reset and starvation sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we, dm_half, dm_byte;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ack, dm_rvalid, dm_fault;
  logic [31:0] dm_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_half, mem_byte;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_half   (dm_half),
    .dm_byte   (dm_byte),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .dm_fault  (dm_fault),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_half  (mem_half),
    .mem_byte  (mem_byte),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [7:0] m [0:63];
  logic [5:0] ma;

  assign ma = mem_addr[5:0];

  always_comb begin
    mem_rdata = '0;
    if (mem_half)
      mem_rdata = {16'h0, m[ma+6'd1], m[ma]};
    else if (mem_byte)
      mem_rdata = {24'h0, m[ma]};
    else
      mem_rdata = {m[ma+6'd3], m[ma+6'd2],
                   m[ma+6'd1], m[ma]};
  end

  always @(posedge clk) begin
    if (mem_write) begin
      m[ma] <= mem_wdata[7:0];
      if (!mem_byte || mem_half)
        m[ma+6'd1] <= mem_wdata[15:8];
      if (!mem_byte && !mem_half) begin
        m[ma+6'd2] <= mem_wdata[23:16];
        m[ma+6'd3] <= mem_wdata[31:24];
      end
    end
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic        dm_half;
    logic        dm_byte;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        e_if_ack;
    logic        e_dm_ack;
    logic        e_rd;
    logic        e_wr;
    logic        e_half;
    logic        e_byte;
    logic [31:0] e_addr;
    logic        e_if_rv;
    logic        e_dm_rv;
    logic        e_fault;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t v [14];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    if_req  = 1'b0;
    if_addr = '0;
    dm_req  = 1'b0;
    dm_we   = 1'b0;
    dm_half = 1'b0;
    dm_byte = 1'b0;
    dm_addr = '0;
    dm_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m[i] = 8'h00;
    m[0] = 8'hFF; m[1] = 8'h54;
    m[2] = 8'h01; m[3] = 8'h02;
    m[4] = 8'h04; m[5] = 8'h08;

    v[0]  = '{1,0, 0,0,0,0,0,0,
              1,0,1,0,0,0,0, 1,0,0,32'h020154FF};
    v[1]  = '{1,0, 1,0,1,0,4,0,
              0,1,1,0,1,0,4, 0,1,0,32'h00000804};
    v[2]  = '{0,0, 1,1,0,0,8,32'hDEADBEEF,
              0,1,0,1,0,0,8, 0,0,0,0};
    v[3]  = '{0,0, 1,0,0,1,32'hA,0,
              0,1,1,0,0,1,32'hA, 0,1,0,32'hAD};
    v[4]  = '{0,0, 1,0,0,0,2,0,
              0,1,0,0,0,0,2, 0,0,1,0};
    v[5]  = '{0,0, 1,1,1,0,1,32'h1234,
              0,1,0,0,1,0,1, 0,0,1,0};
    v[6]  = '{0,0, 1,0,0,1,1,0,
              0,1,1,0,0,1,1, 0,1,0,32'h54};
    v[7]  = '{0,0, 1,0,0,0,8,0,
              0,1,1,0,0,0,8, 0,1,0,32'hDEADBEEF};
    v[8]  = '{0,0, 0,0,0,0,0,0,
              0,0,0,0,0,0,0, 0,0,0,0};
    v[9]  = '{1,8, 0,0,0,0,0,0,
              1,0,1,0,0,0,8, 1,0,0,32'hDEADBEEF};
    v[10] = '{0,0, 1,0,1,0,32'hA,0,
              0,1,1,0,1,0,32'hA, 0,1,0,32'hDEAD};
    v[11] = '{0,0, 1,0,1,1,4,0,
              0,1,1,0,1,0,4, 0,1,0,32'h0804};
    v[12] = '{0,0, 1,1,0,1,3,32'hFFFFFF77,
              0,1,0,1,0,1,3, 0,0,0,0};
    v[13] = '{1,0, 0,0,0,0,0,0,
              1,0,1,0,0,0,0, 1,0,0,32'h770154FF};

    // Reset with both requesters active.
    rst_n    = 1'b0;
    idle();
    if_req   = 1'b1;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h0;
    dm_wdata = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_ack", {31'b0, if_ack}, 0);
    chk("rst_dm_ack", {31'b0, dm_ack}, 0);
    chk("rst_mem_read", {31'b0, mem_read}, 0);
    chk("rst_mem_write", {31'b0, mem_write}, 0);
    idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_if_rvalid", {31'b0, if_rvalid}, 0);
    chk("rst_dm_rvalid", {31'b0, dm_rvalid}, 0);
    chk("rst_dm_fault", {31'b0, dm_fault}, 0);
    chk("rst_if_rdata", if_rdata, 0);

    // Table vectors: comb outputs mid-cycle, responses next cycle.
    for (int i = 0; i < 14; i++) begin
      if_req   = v[i].if_req;
      if_addr  = v[i].if_addr;
      dm_req   = v[i].dm_req;
      dm_we    = v[i].dm_we;
      dm_half  = v[i].dm_half;
      dm_byte  = v[i].dm_byte;
      dm_addr  = v[i].dm_addr;
      dm_wdata = v[i].dm_wdata;
      #2;
      chk($sformatf("v%0d_if_ack", i),
          {31'b0, if_ack}, {31'b0, v[i].e_if_ack});
      chk($sformatf("v%0d_dm_ack", i),
          {31'b0, dm_ack}, {31'b0, v[i].e_dm_ack});
      chk($sformatf("v%0d_mem_read", i),
          {31'b0, mem_read}, {31'b0, v[i].e_rd});
      chk($sformatf("v%0d_mem_write", i),
          {31'b0, mem_write}, {31'b0, v[i].e_wr});
      chk($sformatf("v%0d_mem_half", i),
          {31'b0, mem_half}, {31'b0, v[i].e_half});
      chk($sformatf("v%0d_mem_byte", i),
          {31'b0, mem_byte}, {31'b0, v[i].e_byte});
      chk($sformatf("v%0d_mem_addr", i),
          mem_addr, v[i].e_addr);
      @(posedge clk);
      #1;
      idle();
      chk($sformatf("v%0d_if_rvalid", i),
          {31'b0, if_rvalid}, {31'b0, v[i].e_if_rv});
      chk($sformatf("v%0d_dm_rvalid", i),
          {31'b0, dm_rvalid}, {31'b0, v[i].e_dm_rv});
      chk($sformatf("v%0d_dm_fault", i),
          {31'b0, dm_fault}, {31'b0, v[i].e_fault});
      if (v[i].e_if_rv)
        chk($sformatf("v%0d_if_rdata", i),
            if_rdata, v[i].e_rdata);
      if (v[i].e_dm_rv)
        chk($sformatf("v%0d_dm_rdata", i),
            dm_rdata, v[i].e_rdata);
    end

    // rvalid lasts exactly one cycle.
    @(posedge clk);
    #1;
    chk("pulse_if_rvalid", {31'b0, if_rvalid}, 0);

    // Starvation: fetch forced through every fifth cycle.
    if_req  = 1'b1;
    if_addr = 32'h4;
    dm_req  = 1'b1;
    dm_addr = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      #2;
      chk($sformatf("starve_c%0d_if_ack", c),
          {31'b0, if_ack}, {31'b0, (c % 5) == 0});
      chk($sformatf("starve_c%0d_dm_ack", c),
          {31'b0, dm_ack}, {31'b0, (c % 5) != 0});
      @(posedge clk);
      #1;
    end
    idle();
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
